// File: rtl/core_pkg.sv
// ----------------------------------------------------------------------------
// core_pkg
// Shared constants for the RV32I five-stage core.
//   XLEN        : datapath width
//   WB_SEL_*    : write-back source select codes (2 bits)
//   F3_*        : load funct3 size/sign codes (3 bits)
// ----------------------------------------------------------------------------
package core_pkg;

    localparam int XLEN = 32;

    // Write-back source select
    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;
    localparam logic [1:0] WB_SEL_NONE = 2'b11;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage : core_pkg

// File: rtl/wb_stage_if.sv
// ----------------------------------------------------------------------------
// wb_stage_if
// Bundle between the MEM stage, the WB stage and the register-file write port.
//   MEM side  : in_valid, stall, flush, in_reg_we, in_rd, in_wb_sel,
//               in_alu_result, in_mem_rdata, in_funct3, in_pc
//   WB side   : addr_rd, data_rd, write_enable, wb_valid, wb_pc, retired_count
//   WB_FWD_EN : adds fwd_valid, fwd_rd, fwd_data for the EX-stage bypass
// Modports: master = MEM/control side driving the stage, slave = wb_stage.
// ----------------------------------------------------------------------------
interface wb_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
);

    logic              in_valid;
    logic              stall;
    logic              flush;
    logic              in_reg_we;
    logic [4:0]        in_rd;
    logic [1:0]        in_wb_sel;
    logic [XLEN-1:0]   in_alu_result;
    logic [XLEN-1:0]   in_mem_rdata;
    logic [2:0]        in_funct3;
    logic [XLEN-1:0]   in_pc;

    logic [31:0]       addr_rd;
    logic [XLEN-1:0]   data_rd;
    logic              write_enable;
    logic              wb_valid;
    logic [XLEN-1:0]   wb_pc;
    logic [CNT_W-1:0]  retired_count;

`ifdef WB_FWD_EN
    logic              fwd_valid;
    logic [4:0]        fwd_rd;
    logic [XLEN-1:0]   fwd_data;

    modport master (
        output in_valid, stall, flush, in_reg_we, in_rd, in_wb_sel,
               in_alu_result, in_mem_rdata, in_funct3, in_pc,
        input  addr_rd, data_rd, write_enable, wb_valid, wb_pc, retired_count,
               fwd_valid, fwd_rd, fwd_data
    );

    modport slave (
        input  in_valid, stall, flush, in_reg_we, in_rd, in_wb_sel,
               in_alu_result, in_mem_rdata, in_funct3, in_pc,
        output addr_rd, data_rd, write_enable, wb_valid, wb_pc, retired_count,
               fwd_valid, fwd_rd, fwd_data
    );
`else
    modport master (
        output in_valid, stall, flush, in_reg_we, in_rd, in_wb_sel,
               in_alu_result, in_mem_rdata, in_funct3, in_pc,
        input  addr_rd, data_rd, write_enable, wb_valid, wb_pc, retired_count
    );

    modport slave (
        input  in_valid, stall, flush, in_reg_we, in_rd, in_wb_sel,
               in_alu_result, in_mem_rdata, in_funct3, in_pc,
        output addr_rd, data_rd, write_enable, wb_valid, wb_pc, retired_count
    );
`endif

endinterface : wb_stage_if

// File: rtl/load_extract.sv
// ----------------------------------------------------------------------------
// load_extract
// Purely combinational load-data alignment and extension.
//   funct3   in  3  load size/sign code (F3_*)
//   byte_off in  2  byte address within the word
//   raw      in  W  aligned word read from data memory
//   data     out W  extracted, sign/zero-extended load value
// Halfword selection uses byte_off[1] only; byte_off[0] is ignored for LH/LHU.
// Unknown funct3 codes return the full word.
// ----------------------------------------------------------------------------
module load_extract #(
    parameter int W = 32
) (
    input  logic [2:0]   funct3,
    input  logic [1:0]   byte_off,
    input  logic [W-1:0] raw,
    output logic [W-1:0] data
);

    import core_pkg::*;

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = raw[{byte_off, 3'b000} +: 8];
        half_v = byte_off[1] ? raw[31:16] : raw[15:0];

        case (funct3)
            F3_LB:   data = {{(W-8){byte_v[7]}}, byte_v};
            F3_LBU:  data = {{(W-8){1'b0}}, byte_v};
            F3_LH:   data = {{(W-16){half_v[15]}}, half_v};
            F3_LHU:  data = {{(W-16){1'b0}}, half_v};
            default: data = raw;
        endcase
    end

endmodule : load_extract

// File: rtl/wb_stage.sv
// ----------------------------------------------------------------------------
// wb_stage
// MEM/WB pipeline register plus write-back logic; drives the register-file
// write port and counts retired instructions.
//   clock  in   core clock, rising-edge
//   reset  in   synchronous, active-high
//   wb     slave modport of wb_stage_if:
//            MEM inputs in_*, stall, flush
//            RF write port addr_rd / data_rd / write_enable
//            status wb_valid, wb_pc, retired_count
//            (WB_FWD_EN) fwd_valid / fwd_rd / fwd_data bypass copy
// Configuration macro: WB_FWD_EN enables the EX-stage bypass outputs.
// Outputs depend only on the stage register; there is no input-to-output path.
// ----------------------------------------------------------------------------
module wb_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic       clock,
    input  logic       reset,
    wb_stage_if.slave  wb
);

    import core_pkg::*;

    // Stage register
    logic              valid_q,  valid_d;
    logic              reg_we_q, reg_we_d;
    logic [4:0]        rd_q,     rd_d;
    logic [1:0]        wb_sel_q, wb_sel_d;
    logic [XLEN-1:0]   alu_q,    alu_d;
    logic [XLEN-1:0]   mem_q,    mem_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [XLEN-1:0]   pc_q,     pc_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;

    always_comb begin
        valid_d  = valid_q;
        reg_we_d = reg_we_q;
        rd_d     = rd_q;
        wb_sel_d = wb_sel_q;
        alu_d    = alu_q;
        mem_d    = mem_q;
        funct3_d = funct3_q;
        pc_d     = pc_q;

        if (wb.flush) begin
            // Bubble: only valid matters, the payload is left as-is.
            valid_d = 1'b0;
        end else if (!wb.stall) begin
            valid_d  = wb.in_valid;
            reg_we_d = wb.in_reg_we;
            rd_d     = wb.in_rd;
            wb_sel_d = wb.in_wb_sel;
            alu_d    = wb.in_alu_result;
            mem_d    = wb.in_mem_rdata;
            funct3_d = wb.in_funct3;
            pc_d     = wb.in_pc;
        end

        // The instruction currently in WB retires when it leaves, even if the
        // slot it vacates is being flushed. Wraps naturally at 2^CNT_W.
        cnt_d = cnt_q + CNT_W'(valid_q && !wb.stall);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q  <= 1'b0;
            reg_we_q <= 1'b0;
            rd_q     <= '0;
            wb_sel_q <= '0;
            alu_q    <= '0;
            mem_q    <= '0;
            funct3_q <= '0;
            pc_q     <= '0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            reg_we_q <= reg_we_d;
            rd_q     <= rd_d;
            wb_sel_q <= wb_sel_d;
            alu_q    <= alu_d;
            mem_q    <= mem_d;
            funct3_q <= funct3_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
        end
    end

    // Write-back source selection
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] wdata;
    logic            wen;

    load_extract #(.W(XLEN)) u_load_extract (
        .funct3   (funct3_q),
        .byte_off (alu_q[1:0]),
        .raw      (mem_q),
        .data     (load_data)
    );

    always_comb begin
        case (wb_sel_q)
            WB_SEL_ALU:  wdata = alu_q;
            WB_SEL_LOAD: wdata = load_data;
            WB_SEL_PC4:  wdata = pc_q + XLEN'(4);
            default:     wdata = '0;
        endcase

        // x0 is never written; a stalled valid entry repeats the same write.
        wen = valid_q && reg_we_q && (rd_q != 5'd0) && (wb_sel_q != WB_SEL_NONE);
    end

    assign wb.addr_rd       = {27'b0, rd_q};
    assign wb.data_rd       = wdata;
    assign wb.write_enable  = wen;
    assign wb.wb_valid      = valid_q;
    assign wb.wb_pc         = pc_q;
    assign wb.retired_count = cnt_q;

`ifdef WB_FWD_EN
    assign wb.fwd_valid = wen;
    assign wb.fwd_rd    = rd_q;
    assign wb.fwd_data  = wdata;
`endif

endmodule : wb_stage

// File: tb/tb_wb_stage.sv
// ----------------------------------------------------------------------------
// tb_wb_stage
// Directed bench for wb_stage. A second instance with a 4-bit counter shares
// the same stimulus so counter wrap-around can be reached in a few cycles.
// ----------------------------------------------------------------------------
module tb_wb_stage;

    logic clock;
    logic reset;

    int tests;
    int fails;

    // Small reference for the retired counter
    logic        m_valid;
    logic [63:0] m_cnt;

    wb_stage_if #(.XLEN(32), .CNT_W(64)) wa ();
    wb_stage_if #(.XLEN(32), .CNT_W(4))  wsm ();

    wb_stage #(.XLEN(32), .CNT_W(64)) dut (
        .clock (clock),
        .reset (reset),
        .wb    (wa.slave)
    );

    wb_stage #(.XLEN(32), .CNT_W(4)) dut_small (
        .clock (clock),
        .reset (reset),
        .wb    (wsm.slave)
    );

    assign wsm.in_valid      = wa.in_valid;
    assign wsm.stall         = wa.stall;
    assign wsm.flush         = wa.flush;
    assign wsm.in_reg_we     = wa.in_reg_we;
    assign wsm.in_rd         = wa.in_rd;
    assign wsm.in_wb_sel     = wa.in_wb_sel;
    assign wsm.in_alu_result = wa.in_alu_result;
    assign wsm.in_mem_rdata  = wa.in_mem_rdata;
    assign wsm.in_funct3     = wa.in_funct3;
    assign wsm.in_pc         = wa.in_pc;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; update the counter reference from the inputs seen at it.
    task automatic tick();
        if (reset) begin
            m_valid = 1'b0;
            m_cnt   = '0;
        end else begin
            if (m_valid && !wa.stall) m_cnt = m_cnt + 64'd1;
            if (wa.flush)           m_valid = 1'b0;
            else if (!wa.stall)     m_valid = wa.in_valid;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic setin(input logic v, input logic we, input logic [4:0] rd,
                         input logic [1:0] sel, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [2:0] f3,
                         input logic [31:0] pc);
        wa.in_valid      = v;
        wa.in_reg_we     = we;
        wa.in_rd         = rd;
        wa.in_wb_sel     = sel;
        wa.in_alu_result = alu;
        wa.in_mem_rdata  = mem;
        wa.in_funct3     = f3;
        wa.in_pc         = pc;
    endtask

    localparam logic [31:0] RAW = 32'h80FF_7F01;

    initial begin
        tests   = 0;
        fails   = 0;
        m_valid = 1'b0;
        m_cnt   = '0;
        reset   = 1'b1;
        wa.stall = 1'b0;
        wa.flush = 1'b0;
        setin(0, 0, 0, 2'b00, 0, 0, 3'b000, 0);
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_we",    64'(wa.write_enable), 64'd0);
        chk("rst_valid", 64'(wa.wb_valid), 64'd0);
        chk("rst_cnt",   wa.retired_count, 64'd0);
        chk("rst_data",  64'(wa.data_rd), 64'd0);

        // ALU write
        setin(1, 1, 5, 2'b00, 32'h1234_5678, 0, 3'b000, 32'h40);
        tick();
        chk("alu_addr",  64'(wa.addr_rd), 64'd5);
        chk("alu_data",  64'(wa.data_rd), 64'h1234_5678);
        chk("alu_we",    64'(wa.write_enable), 64'd1);
        chk("alu_pc",    64'(wa.wb_pc), 64'h40);
        chk("alu_cnt0",  wa.retired_count, 64'd0);

        // Loads from RAW
        setin(1, 1, 10, 2'b01, 32'h1001, RAW, 3'b000, 32'h44);
        tick();
        chk("alu_cnt1",  wa.retired_count, 64'd1);
        chk("lb_off1",   64'(wa.data_rd), 64'h0000_007F);
        chk("lb_addr",   64'(wa.addr_rd), 64'd10);
        setin(1, 1, 10, 2'b01, 32'h1003, RAW, 3'b000, 32'h48);
        tick();
        chk("lb_off3",   64'(wa.data_rd), 64'hFFFF_FF80);
        setin(1, 1, 10, 2'b01, 32'h1002, RAW, 3'b100, 32'h4C);
        tick();
        chk("lbu_off2",  64'(wa.data_rd), 64'h0000_00FF);
        setin(1, 1, 10, 2'b01, 32'h1002, RAW, 3'b001, 32'h50);
        tick();
        chk("lh_off2",   64'(wa.data_rd), 64'hFFFF_80FF);
        setin(1, 1, 10, 2'b01, 32'h1003, RAW, 3'b001, 32'h54);
        tick();
        chk("lh_off3",   64'(wa.data_rd), 64'hFFFF_80FF);
        setin(1, 1, 10, 2'b01, 32'h1000, RAW, 3'b101, 32'h58);
        tick();
        chk("lhu_off0",  64'(wa.data_rd), 64'h0000_7F01);
        setin(1, 1, 10, 2'b01, 32'h1002, RAW, 3'b010, 32'h5C);
        tick();
        chk("lw",        64'(wa.data_rd), 64'h80FF_7F01);
        setin(1, 1, 10, 2'b01, 32'h1001, RAW, 3'b011, 32'h60);
        tick();
        chk("f3_other",  64'(wa.data_rd), 64'h80FF_7F01);
        chk("load_cnt",  wa.retired_count, 64'd8);

        // x0 write suppressed, data still follows the mux
        setin(1, 1, 0, 2'b00, 32'h0000_DEAD, 0, 3'b000, 32'h64);
        tick();
        chk("x0_we",     64'(wa.write_enable), 64'd0);
        chk("x0_data",   64'(wa.data_rd), 64'h0000_DEAD);
        chk("x0_valid",  64'(wa.wb_valid), 64'd1);
        setin(1, 0, 7, 2'b00, 32'h77, 0, 3'b000, 32'h68);
        tick();
        chk("x0_cnt",    wa.retired_count, 64'd10);
        chk("nowe_we",   64'(wa.write_enable), 64'd0);
        setin(1, 1, 7, 2'b11, 32'h77, 0, 3'b000, 32'h6C);
        tick();
        chk("none_we",   64'(wa.write_enable), 64'd0);
        chk("none_data", 64'(wa.data_rd), 64'd0);

        // JAL link value
        setin(1, 1, 1, 2'b10, 32'h0, 0, 3'b000, 32'h0000_0100);
        tick();
        chk("jal_data",  64'(wa.data_rd), 64'h104);
        chk("jal_we",    64'(wa.write_enable), 64'd1);
        setin(1, 1, 1, 2'b10, 32'h0, 0, 3'b000, 32'hFFFF_FFFC);
        tick();
        chk("jal_wrap",  64'(wa.data_rd), 64'd0);
        chk("jal_cnt",   wa.retired_count, m_cnt);

        // Stall 3 cycles with a valid write held in WB
        setin(1, 1, 9, 2'b00, 32'hCAFE_F00D, 0, 3'b000, 32'h200);
        tick();
        chk("pre_stall_cnt", wa.retired_count, 64'd14);
        wa.stall = 1'b1;
        setin(1, 1, 3, 2'b00, 32'h1111_1111, 0, 3'b000, 32'h300);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_data", 64'(wa.data_rd), 64'hCAFE_F00D);
            chk("stall_addr", 64'(wa.addr_rd), 64'd9);
            chk("stall_we",   64'(wa.write_enable), 64'd1);
            chk("stall_cnt",  wa.retired_count, 64'd14);
        end
        wa.stall = 1'b0;
        setin(0, 0, 0, 2'b00, 0, 0, 3'b000, 0);
        tick();
        chk("unstall_cnt",   wa.retired_count, 64'd15);
        chk("unstall_valid", 64'(wa.wb_valid), 64'd0);

        // flush + stall together
        setin(1, 1, 4, 2'b00, 32'h44, 0, 3'b000, 32'h400);
        tick();
        wa.flush = 1'b1;
        wa.stall = 1'b1;
        tick();
        chk("fs_valid",  64'(wa.wb_valid), 64'd0);
        chk("fs_we",     64'(wa.write_enable), 64'd0);
        chk("fs_cnt",    wa.retired_count, 64'd15);
        wa.stall = 1'b0;

        // flush alone still retires the outgoing instruction
        wa.flush = 1'b0;
        tick();
        wa.flush = 1'b1;
        tick();
        chk("fl_valid",  64'(wa.wb_valid), 64'd0);
        chk("fl_cnt",    wa.retired_count, 64'd16);
        wa.flush = 1'b0;

        // Reset with a write pending
        setin(1, 1, 6, 2'b00, 32'h66, 0, 3'b000, 32'h500);
        tick();
        chk("pend_we",   64'(wa.write_enable), 64'd1);
        reset = 1'b1;
        tick();
        chk("rstp_we",   64'(wa.write_enable), 64'd0);
        chk("rstp_cnt",  wa.retired_count, 64'd0);
        chk("rstp_small", 64'(wsm.retired_count), 64'd0);
        reset = 1'b0;

        // Counter wrap on the 4-bit instance
        setin(1, 1, 2, 2'b00, 32'h22, 0, 3'b000, 32'h600);
        for (int i = 0; i < 16; i++) tick();
        chk("wrap_big15",   wa.retired_count, 64'd15);
        chk("wrap_small15", 64'(wsm.retired_count), 64'hF);
        setin(0, 0, 0, 2'b00, 0, 0, 3'b000, 0);
        tick();
        chk("wrap_big16",   wa.retired_count, 64'd16);
        chk("wrap_small0",  64'(wsm.retired_count), 64'd0);
        chk("model_cnt",    wa.retired_count, m_cnt);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_wb_stage
